dmem_access_unit: RTL and testbench

- Load/store unit between the MIPS datapath and the word-organised synchronous-write / asynchronous-read data memory.
- The data memory accepts only whole 32-bit words. This block converts byte, halfword and word loads and stores into word accesses.
- Sub-word stores are done as read-modify-write. Load results are sign- or zero-extended.
- Exposes a simple req/ready/done handshake to the datapath and checks alignment.

---
 rtl/dmem_access_unit_if.sv | 30 +++
 rtl/dmem_access_unit.sv | 114 +++++++++++
 tb/tb_dmem_access_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Bus bundle for the load/store unit: datapath request/response side plus the
// word-wide data memory side. The unit itself uses the slave modport.
interface dmem_access_unit_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  req;
  logic                  wr;
  logic [1:0]            size;
  logic                  uns;
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic [31:0]           rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport master (
    output req, wr, size, uns, addr, wdata, mem_rdata,
    input  ready, done, err, rdata, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  req, wr, size, uns, addr, wdata, mem_rdata,
    output ready, done, err, rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store unit: turns byte/half/word loads and stores into whole-word memory
// accesses, with read-modify-write for sub-word stores and alignment checking.
module dmem_access_unit #(
  parameter int ADDR_WIDTH = 6
) (
  input logic               clk,
  input logic               reset,
  dmem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

  state_t                state;
  state_t                next_state;
  logic                  cap_wr;
  logic                  cap_uns;
  logic [1:0]            cap_size;
  logic [ADDR_WIDTH+1:0] cap_addr;
  logic [31:0]           cap_wdata;
  logic [31:0]           merge_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  misaligned;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [31:0]           load_val;
  logic [31:0]           merge_val;

  always_comb begin
    misaligned = (bus.size == 2'b11) ||
                 ((bus.size == 2'b01) && bus.addr[0]) ||
                 ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));
  end

  // Word stores skip the read phase; everything else reads the word first.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (misaligned)
            next_state = DONE;
          else if (bus.wr && (bus.size == 2'b10))
            next_state = WRITE;
          else
            next_state = ACCESS;
        end
      end
      ACCESS:  next_state = cap_wr ? WRITE : DONE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    byte_lane = bus.mem_rdata[{cap_addr[1:0], 3'b000} +: 8];
    half_lane = bus.mem_rdata[{cap_addr[1], 4'b0000} +: 16];
    case (cap_size)
      2'b00:   load_val = {{24{~cap_uns & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{16{~cap_uns & half_lane[15]}}, half_lane};
      default: load_val = bus.mem_rdata;
    endcase
    merge_val = bus.mem_rdata;
    if (cap_size == 2'b00)
      merge_val[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
    else
      merge_val[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
  end

  // Capture on acceptance so later input changes cannot disturb the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cap_wr    <= 1'b0;
      cap_uns   <= 1'b0;
      cap_size  <= 2'b00;
      cap_addr  <= '0;
      cap_wdata <= '0;
      merge_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (bus.req) begin
            cap_wr    <= bus.wr;
            cap_uns   <= bus.uns;
            cap_size  <= bus.size;
            cap_addr  <= bus.addr[ADDR_WIDTH+1:0];
            cap_wdata <= bus.wdata;
            err_q     <= misaligned;
          end
        end
        ACCESS: begin
          if (cap_wr)
            merge_q <= merge_val;
          else
            rdata_q <= load_val;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done      = (state == DONE);
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = cap_addr[ADDR_WIDTH+1:2];
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_wdata = (state != WRITE) ? 32'h0 :
                         (cap_size == 2'b10) ? cap_wdata : merge_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: directed accesses push expectations,
// a monitor pops and checks them whenever done pulses.
module tb_dmem_access_unit;
  localparam int AW = 6;

  typedef struct {
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          due;
    int          exp_we;
    bit          chk_mem;
    int          mem_idx;
    logic [31:0] exp_mem;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem [0:63];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  logic [31:0] held_rdata = 32'h0;

  dmem_access_unit_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural memory: asynchronous read, write committed on the rising edge.
  assign bus.mem_rdata = mem[bus.mem_addr];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h5A5A0FF0;
    forever begin
      @(posedge clk);
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check_output("rst_ready", 32'(bus.ready), 32'h1);
    check_output("rst_done", 32'(bus.done), 32'h0);
    check_output("rst_err", 32'(bus.err), 32'h0);
    check_output("rst_rdata", bus.rdata, 32'h0);
    check_output("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check_output("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check_output("rst_mem_wdata", bus.mem_wdata, 32'h0);
  endtask

  // Called at a negedge; returns at the negedge after the request was accepted.
  task automatic apply_stimulus(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic e_err, input logic [31:0] ld_val,
                                input bit chk_m, input logic [31:0] m_val, input bit hold);
    exp_t e;
    int   n = 0;
    bus.wr = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = wd;
    bus.req = 1'b1;
    while (!bus.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      checks++; errors++;
      $display("[TB] FAIL ready_timeout: got ready=0 expected ready=1 within 20 cycles");
      bus.req = 1'b0;
      return;
    end
    if (!w && !e_err) held_rdata = ld_val;
    e.exp_err   = e_err;
    e.exp_rdata = held_rdata;
    e.due       = cyc + (e_err ? 1 : (w && sz != 2'b10) ? 3 : 2);
    e.exp_we    = (w && !e_err) ? 1 : 0;
    e.chk_mem   = chk_m;
    e.mem_idx   = int'(a[7:2]);
    e.exp_mem   = m_val;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !bus.ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        we_cnt = 0;
      end else begin
        if (bus.mem_we) we_cnt++;
        if (bus.done) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_done: got done=1 expected no pending access");
          end else begin
            e = sb.pop_front();
            check_output("err", 32'(bus.err), 32'(e.exp_err));
            check_output("rdata", bus.rdata, e.exp_rdata);
            check_output("latency_cycle", 32'(cyc), 32'(e.due));
            check_output("mem_we_cycles", 32'(we_cnt), 32'(e.exp_we));
            if (e.chk_mem) check_output("mem_word", mem[e.mem_idx], e.exp_mem);
          end
          we_cnt = 0;
        end
      end
    end
  end

  initial begin
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clk);

    // Word path, sub-word loads and read-modify-write stores on mem[3].
    apply_stimulus(1, 2'b10, 0, 32'h0C, 32'hDEADBEEF, 0, 32'h0, 1, 32'hDEADBEEF, 0);
    apply_stimulus(0, 2'b10, 0, 32'h0C, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0, 0);
    apply_stimulus(0, 2'b00, 0, 32'h0D, 32'h0, 0, 32'hFFFFFFBE, 0, 32'h0, 0);
    apply_stimulus(0, 2'b00, 1, 32'h0D, 32'h0, 0, 32'h000000BE, 0, 32'h0, 0);
    apply_stimulus(0, 2'b01, 0, 32'h0E, 32'h0, 0, 32'hFFFFDEAD, 0, 32'h0, 0);
    apply_stimulus(0, 2'b01, 1, 32'h0C, 32'h0, 0, 32'h0000BEEF, 0, 32'h0, 0);
    apply_stimulus(1, 2'b00, 0, 32'h0E, 32'h12345677, 0, 32'h0, 1, 32'hDE77BEEF, 0);
    apply_stimulus(1, 2'b01, 0, 32'h0C, 32'hAAAA1234, 0, 32'h0, 1, 32'hDE771234, 0);
    apply_stimulus(0, 2'b10, 0, 32'h0C, 32'h0, 0, 32'hDE771234, 0, 32'h0, 0);
    apply_stimulus(0, 2'b00, 0, 32'h0F, 32'h0, 0, 32'hFFFFFFDE, 0, 32'h0, 0);
    apply_stimulus(0, 2'b00, 1, 32'h0C, 32'h0, 0, 32'h00000034, 0, 32'h0, 0);

    // Misaligned and illegal-size requests.
    apply_stimulus(1, 2'b10, 0, 32'h0D, 32'h11111111, 1, 32'h0, 1, 32'hDE771234, 0);
    apply_stimulus(0, 2'b01, 0, 32'h03, 32'h0, 1, 32'h0, 0, 32'h0, 0);
    apply_stimulus(0, 2'b11, 0, 32'h08, 32'h0, 1, 32'h0, 0, 32'h0, 0);

    // req held high across back-to-back accesses on mem[1].
    apply_stimulus(1, 2'b10, 0, 32'h04, 32'h00008001, 0, 32'h0, 1, 32'h00008001, 1);
    apply_stimulus(0, 2'b10, 0, 32'h04, 32'h0, 0, 32'h00008001, 0, 32'h0, 1);
    apply_stimulus(1, 2'b01, 0, 32'h06, 32'hFFFFC3C3, 0, 32'h0, 1, 32'hC3C38001, 1);
    apply_stimulus(0, 2'b01, 0, 32'h06, 32'h0, 0, 32'hFFFFC3C3, 0, 32'h0, 1);
    apply_stimulus(0, 2'b01, 1, 32'h04, 32'h0, 0, 32'h00008001, 0, 32'h0, 0);
    drain();

    // Reset asserted during the WRITE cycle of a word store to mem[4].
    bus.wr = 1'b1; bus.size = 2'b10; bus.uns = 1'b0;
    bus.addr = 32'h10; bus.wdata = 32'hCAFEF00D; bus.req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    check_output("write_phase_we", 32'(bus.mem_we), 32'h1);
    #1 reset = 1'b1;
    #1 check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    check_output("aborted_store_mem", mem[4], 32'h5A5A0FF0);
    reset = 1'b0;
    held_rdata = 32'h0;
    @(negedge clk);
    apply_stimulus(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h5A5A0FF0, 0, 32'h0, 0);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
